// File: rtl/mem_burst_pkg.sv
// Shared types and defaults for the mem_burst_master slice.
// Optional abort support is enabled by defining MEM_BURST_ABORT_EN.
package mem_burst_pkg;

    localparam int DEF_DATA_W = 2;
    localparam int DEF_ADDR_W = 4;

    localparam logic CMD_WRITE = 1'b1;
    localparam logic CMD_READ  = 1'b0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WRITE  = 3'd1,
        READ   = 3'd2,
        RDRAIN = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/mem_burst_addr_gen.sv
// Burst address walker: current address wraps modulo depth, beat counter counts
// down to zero and flags the final beat.
module mem_burst_addr_gen
    import mem_burst_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_start_addr,
    input  logic [ADDR_W-1:0] i_len,
    input  logic              i_advance,
    output logic [ADDR_W-1:0] o_cur_addr,
    output logic              o_last
);

    logic [ADDR_W-1:0] r_cur_addr;
    logic [ADDR_W-1:0] r_beats_left;

    // The counter parks at zero on the final beat instead of underflowing.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cur_addr   <= '0;
            r_beats_left <= '0;
        end else if (i_load) begin
            r_cur_addr   <= i_start_addr;
            r_beats_left <= i_len;
        end else if (i_advance) begin
            r_cur_addr <= r_cur_addr + 1'b1;
            if (r_beats_left != '0) begin
                r_beats_left <= r_beats_left - 1'b1;
            end
        end
    end

    assign o_cur_addr = r_cur_addr;
    assign o_last     = (r_beats_left == '0);

endmodule

// File: rtl/mem_burst_master.sv
// Burst initiator for the 16x2 single-port mini memory.
// Define MEM_BURST_ABORT_EN to add the abort input and aborted pulse.
module mem_burst_master
    import mem_burst_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              mem_wre,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done
`ifdef MEM_BURST_ABORT_EN
    ,
    input  logic              abort,
    output logic              aborted
`endif
);

    state_t            r_state;
    logic [ADDR_W-1:0] w_cur_addr;
    logic              w_last;
    logic              w_load;
    logic              w_advance;
    logic              w_rd_load;
    logic              w_abort;

`ifdef MEM_BURST_ABORT_EN
    assign w_abort = abort && ((r_state == WRITE) || (r_state == READ) || (r_state == RDRAIN));
`else
    assign w_abort = 1'b0;
`endif

    // Reset gates the write strobe so an interrupted burst cannot land one more beat.
    assign cmd_ready = (r_state == IDLE);
    assign wr_ready  = (r_state == WRITE);
    assign mem_wre   = (r_state == WRITE) && wr_valid && !w_abort && !rst;
    assign mem_addr  = w_cur_addr;
    assign mem_wdata = wr_data;

    assign w_load    = (r_state == IDLE) && cmd_valid;
    assign w_rd_load = (r_state == READ) && (!rd_valid || rd_ready) && !w_abort;
    assign w_advance = mem_wre || w_rd_load;

    mem_burst_addr_gen #(
        .ADDR_W(ADDR_W)
    ) u_addr_gen (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_load      (w_load),
        .i_start_addr(cmd_addr),
        .i_len       (cmd_len),
        .i_advance   (w_advance),
        .o_cur_addr  (w_cur_addr),
        .o_last      (w_last)
    );

    // Output registers are set on the transition into a state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
`ifdef MEM_BURST_ABORT_EN
            aborted  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef MEM_BURST_ABORT_EN
            aborted <= 1'b0;
            if (w_abort) begin
                r_state  <= DONE;
                rd_valid <= 1'b0;
                done     <= 1'b1;
                aborted  <= 1'b1;
            end else
`endif
            begin
                unique case (r_state)
                    IDLE: begin
                        if (cmd_valid) begin
                            r_state <= (cmd_write == CMD_WRITE) ? WRITE : READ;
                            busy    <= 1'b1;
                        end
                    end
                    WRITE: begin
                        if (wr_valid && w_last) begin
                            r_state <= DONE;
                            done    <= 1'b1;
                        end
                    end
                    READ: begin
                        if (w_rd_load) begin
                            rd_data  <= mem_rdata;
                            rd_valid <= 1'b1;
                            if (w_last) begin
                                r_state <= RDRAIN;
                            end
                        end
                    end
                    RDRAIN: begin
                        if (rd_ready) begin
                            rd_valid <= 1'b0;
                            r_state  <= DONE;
                            done     <= 1'b1;
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end
                    default: begin
                        r_state  <= IDLE;
                        busy     <= 1'b0;
                        rd_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master with a behavioural 16x2 memory attached.
// Abort steps are included when MEM_BURST_ABORT_EN is defined.
module tb_mem_burst_master;
    import mem_burst_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [3:0] cmd_addr;
    logic [3:0] cmd_len;
    logic [1:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic [1:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic       mem_wre;
    logic [3:0] mem_addr;
    logic [1:0] mem_wdata;
    logic [1:0] mem_rdata;
    logic       busy;
    logic       done;
`ifdef MEM_BURST_ABORT_EN
    logic       abort;
    logic       aborted;
`endif

    int checks = 0;
    int errors = 0;

    logic [1:0] mem [16];
    logic [1:0] wrData [16];
    logic [1:0] expData [16];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wre) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    mem_burst_master dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .mem_wre  (mem_wre),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy),
        .done     (done)
`ifdef MEM_BURST_ABORT_EN
        ,
        .abort    (abort),
        .aborted  (aborted)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic cv, input logic cw, input logic [3:0] ca,
                                 input logic [3:0] cl, input logic wv, input logic [1:0] wd,
                                 input logic rr);
        cmd_valid = cv;
        cmd_write = cw;
        cmd_addr  = ca;
        cmd_len   = cl;
        wr_valid  = wv;
        wr_data   = wd;
        rd_ready  = rr;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Write burst from wrData; one beat per cycle with wr_valid held high.
    task automatic writeBurst(input logic [3:0] a, input logic [3:0] l);
        applyStimulus(1'b1, CMD_WRITE, a, l, 1'b0, 2'd0, 1'b0);
        tick;
        cmd_valid = 1'b0;
        for (int i = 0; i <= int'(l); i++) begin
            wr_valid = 1'b1;
            wr_data  = wrData[i];
            #1;
            checkOutput("wr_ready", wr_ready, 1);
            checkOutput("wr_mem_wre", mem_wre, 1);
            checkOutput("wr_mem_addr", mem_addr, (int'(a) + i) % 16);
            checkOutput("wr_mem_wdata", mem_wdata, wrData[i]);
            tick;
        end
        wr_valid = 1'b0;
        #1;
        checkOutput("wr_done_pulse", done, 1);
        checkOutput("wr_done_busy", busy, 1);
        checkOutput("wr_done_cmd_ready", cmd_ready, 0);
        checkOutput("wr_done_mem_wre", mem_wre, 0);
        tick;
        checkOutput("wr_idle_done", done, 0);
        checkOutput("wr_idle_busy", busy, 0);
    endtask

    // Read burst against expData; toggle=1 alternates rd_ready 1,0,1,0.
    task automatic readBurst(input logic [3:0] a, input logic [3:0] l, input bit toggle);
        int idx;
        bit stallPrev;
        bit seenDone;
        logic [1:0] heldVal;
        idx = 0;
        stallPrev = 1'b0;
        seenDone = 1'b0;
        heldVal = 2'd0;
        applyStimulus(1'b1, CMD_READ, a, l, 1'b0, 2'd0, 1'b1);
        tick;
        cmd_valid = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (done) begin
                seenDone = 1'b1;
                break;
            end
            rd_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            if (stallPrev) checkOutput("rd_hold", rd_data, heldVal);
            if (rd_valid && rd_ready) begin
                if (idx < 16) checkOutput("rd_beat", rd_data, expData[idx]);
                idx++;
            end
            stallPrev = rd_valid && !rd_ready;
            heldVal = rd_data;
            tick;
        end
        checkOutput("rd_done_seen", seenDone, 1);
        checkOutput("rd_beat_count", idx, int'(l) + 1);
        checkOutput("rd_valid_at_done", rd_valid, 0);
        rd_ready = 1'b0;
        tick;
        checkOutput("rd_idle_busy", busy, 0);
    endtask

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bit seen;
        rst = 1'b1;
`ifdef MEM_BURST_ABORT_EN
        abort = 1'b0;
`endif
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'd0, 1'b0);
        tick;
        tick;
        checkOutput("rst_cmd_ready", cmd_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_rd_valid", rd_valid, 0);
        checkOutput("rst_rd_data", rd_data, 0);
        checkOutput("rst_mem_wre", mem_wre, 0);
        checkOutput("rst_wr_ready", wr_ready, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        rst = 1'b0;
        tick;

        // wr_valid in IDLE must never reach the memory
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 2'd3, 1'b0);
        #1;
        checkOutput("idle_wr_mem_wre", mem_wre, 0);
        checkOutput("idle_wr_ready", wr_ready, 0);
        wr_valid = 1'b0;
        tick;

        // Fill: addr i <- i % 4
        wrData = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3,
                   2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        writeBurst(4'd0, 4'd15);

        wrData = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
                   2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        writeBurst(4'd3, 4'd3);
        expData = wrData;
        readBurst(4'd3, 4'd3, 1'b0);

        // Wrapping burst 14,15,0,1
        wrData = '{2'd2, 2'd1, 2'd3, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0,
                   2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        writeBurst(4'd14, 4'd3);
        expData = wrData;
        readBurst(4'd14, 4'd3, 1'b0);

        // Reset after two of four beats at addr 8
        applyStimulus(1'b1, CMD_WRITE, 4'd8, 4'd3, 1'b0, 2'd0, 1'b0);
        tick;
        cmd_valid = 1'b0;
        wr_valid = 1'b1;
        wr_data = 2'd3;
        tick;
        wr_data = 2'd2;
        tick;
        wr_data = 2'd1;
        rst = 1'b1;
        #1;
        checkOutput("rstmid_mem_wre_during", mem_wre, 0);
        tick;
        rst = 1'b0;
        #1;
        checkOutput("rstmid_busy", busy, 0);
        checkOutput("rstmid_cmd_ready", cmd_ready, 1);
        checkOutput("rstmid_mem_wre", mem_wre, 0);
        checkOutput("rstmid_wr_ready", wr_ready, 0);
        wr_valid = 1'b0;
        tick;
        expData = '{2'd3, 2'd2, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0,
                    2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        readBurst(4'd8, 4'd3, 1'b0);

        // Full 16-beat read with rd_ready toggling
        expData = '{2'd3, 2'd1, 2'd2, 2'd1, 2'd2, 2'd3, 2'd0, 2'd3,
                    2'd3, 2'd2, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd1};
        readBurst(4'd0, 4'd15, 1'b1);

        // cmd_valid held high throughout a 2-beat read
        applyStimulus(1'b1, CMD_READ, 4'd0, 4'd1, 1'b0, 2'd0, 1'b1);
        #1;
        checkOutput("hold_idle_cmd_ready", cmd_ready, 1);
        tick;
        checkOutput("hold_read_cmd_ready", cmd_ready, 0);
        checkOutput("hold_read_busy", busy, 1);
        tick;
        checkOutput("hold_beat0_valid", rd_valid, 1);
        checkOutput("hold_beat0_data", rd_data, 3);
        checkOutput("hold_beat0_cmd_ready", cmd_ready, 0);
        tick;
        checkOutput("hold_beat1_data", rd_data, 1);
        checkOutput("hold_drain_cmd_ready", cmd_ready, 0);
        tick;
        checkOutput("hold_done", done, 1);
        checkOutput("hold_done_cmd_ready", cmd_ready, 0);
        tick;
        checkOutput("hold_idle_busy", busy, 0);
        checkOutput("hold_idle_cmd_ready2", cmd_ready, 1);
        tick;
        checkOutput("hold_second_busy", busy, 1);
        cmd_valid = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            tick;
        end
        checkOutput("hold_second_done", seen, 1);
        tick;
        checkOutput("hold_second_idle", busy, 0);

`ifdef MEM_BURST_ABORT_EN
        // Abort while the first read beat is presented
        applyStimulus(1'b1, CMD_READ, 4'd0, 4'd3, 1'b0, 2'd0, 1'b1);
        tick;
        cmd_valid = 1'b0;
        tick;
        checkOutput("abort_beat0_valid", rd_valid, 1);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        checkOutput("abort_done", done, 1);
        checkOutput("abort_aborted", aborted, 1);
        checkOutput("abort_rd_valid", rd_valid, 0);
        tick;
        checkOutput("abort_idle_busy", busy, 0);
        checkOutput("abort_idle_aborted", aborted, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
